// File: rtl/nco_dac_sequencer_if.sv
// Sequencer <-> SineLUT / DAC_SPI_Out signal bundle.
// master = sequencer side, slave = LUT + SPI side.
interface nco_dac_sequencer_if #(
    parameter int LUT_ADDR_W = 10,
    parameter int SAMPLE_W   = 16
);
    logic [LUT_ADDR_W-1:0] lut_addr;
    logic [SAMPLE_W-1:0]   lut_value;
    logic [SAMPLE_W+7:0]   dac_data;
    logic                  dac_send;
    logic                  dac_busy;

    modport master (output lut_addr, dac_data, dac_send, input lut_value, dac_busy);
    modport slave  (input lut_addr, dac_data, dac_send, output lut_value, dac_busy);
endinterface

// File: rtl/nco_dac_sequencer.sv
// Multi-channel NCO: sample timer, per-channel phase accumulators, and a
// frame sequencer that reads the shared sine LUT and feeds MAX5134 command
// words to the DAC SPI block.
// Optional macro SIGNED_LUT_EN: treat LUT samples as two's complement and
// convert to offset binary by inverting the MSB before packing.

// One oscillator channel: frequency register, phase accumulator and the
// LUT address snapshot taken when a frame starts.
module nco_dac_sequencer_lane #(
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  tick_i,
    input  logic                  snap_en_i,
    input  logic [PHASE_W-1:0]    freq_i,
    output logic [LUT_ADDR_W-1:0] snap_o
);
    logic [PHASE_W-1:0]    freq_q, phase_q;
    logic [LUT_ADDR_W-1:0] snap_q;

    // tick reads the old freq_q, so a same-cycle load applies from the next tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            freq_q  <= '0;
            phase_q <= '0;
            snap_q  <= '0;
        end else begin
            if (load_i) freq_q <= freq_i;
            if (tick_i) phase_q <= phase_q + freq_q;
            if (tick_i && snap_en_i) snap_q <= phase_q[PHASE_W-1 -: LUT_ADDR_W];
        end
    end

    assign snap_o = snap_q;
endmodule

module nco_dac_sequencer #(
    parameter int CHANNELS        = 2,
    parameter int PHASE_W         = 24,
    parameter int LUT_ADDR_W      = 10,
    parameter int SAMPLE_W        = 16,
    parameter int SAMPLE_INTERVAL = 2015
) (
    input  logic               clock_in,
    input  logic               rstn,
    input  logic               enable,
    input  logic               freq_load,
    input  logic [1:0]         freq_ch,
    input  logic [PHASE_W-1:0] freq_in,
    output logic               sample_tick,
    output logic               overrun,
    input  logic               overrun_clr,
    nco_dac_sequencer_if.master dac_if
);
    localparam int         CNT_W   = $clog2(SAMPLE_INTERVAL);
    localparam logic [1:0] LAST_CH = 2'(CHANNELS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LUTWAIT, SEND, HOLD, DRAIN} state_t;

    state_t                              state_q;
    logic [1:0]                          ch_q;
    logic [LUT_ADDR_W-1:0]               lut_addr_q, snap_sel;
    logic [SAMPLE_W+7:0]                 dac_data_q;
    logic                                dac_send_q, overrun_q;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                tick;
    logic [CHANNELS-1:0][LUT_ADDR_W-1:0] snap;
    logic [SAMPLE_W-1:0]                 sample;
    logic [3:0]                          onehot;

    assign tick = enable && (cnt_q == CNT_W'(SAMPLE_INTERVAL - 1));

    // sample timer: wraps on tick, parked at zero while disabled
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable || tick) cnt_d = '0;
    end

    // timer register
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // phases advance on every tick; the snapshot is only taken when a new
    // frame actually starts so a dropped tick cannot disturb a running frame
    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        nco_dac_sequencer_lane #(.PHASE_W(PHASE_W), .LUT_ADDR_W(LUT_ADDR_W)) u_lane (
            .clk_i     (clock_in),
            .rst_ni    (rstn),
            .load_i    (freq_load && (freq_ch == 2'(n))),
            .tick_i    (tick),
            .snap_en_i (state_q == IDLE),
            .freq_i    (freq_in),
            .snap_o    (snap[n])
        );
    end

    // pick the current channel's snapshot without a width-mismatched index
    always_comb begin
        snap_sel = '0;
        for (int n = 0; n < CHANNELS; n++)
            if (ch_q == 2'(n)) snap_sel = snap[n];
    end

`ifdef SIGNED_LUT_EN
    assign sample = {~dac_if.lut_value[SAMPLE_W-1], dac_if.lut_value[SAMPLE_W-2:0]};
`else
    assign sample = dac_if.lut_value;
`endif

    // command byte is 0x3 (write-through) followed by the one-hot DAC select
    assign onehot = 4'b0001 << ch_q;

    // frame sequencer: one LUT read and one SPI word per channel
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            lut_addr_q <= '0;
            dac_data_q <= '0;
            dac_send_q <= 1'b0;
        end else begin
            dac_send_q <= 1'b0;
            case (state_q)
                IDLE: if (tick) begin
                    ch_q    <= '0;
                    state_q <= ADDR;
                end
                ADDR: begin
                    lut_addr_q <= snap_sel;
                    state_q    <= LUTWAIT;
                end
                LUTWAIT: state_q <= SEND;
                SEND: if (!dac_if.dac_busy) begin
                    dac_data_q <= {4'b0011, onehot, sample};
                    dac_send_q <= 1'b1;
                    state_q    <= HOLD;
                end
                // gives the SPI block one cycle to raise busy after the strobe
                HOLD: state_q <= DRAIN;
                DRAIN: if (!dac_if.dac_busy) begin
                    if (ch_q == LAST_CH) state_q <= IDLE;
                    else begin
                        ch_q    <= ch_q + 2'd1;
                        state_q <= ADDR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // sticky overrun; a set in the same cycle as a clear wins
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn)                         overrun_q <= 1'b0;
        else if (tick && state_q != IDLE)  overrun_q <= 1'b1;
        else if (overrun_clr)              overrun_q <= 1'b0;
    end

    assign sample_tick     = tick;
    assign overrun         = overrun_q;
    assign dac_if.lut_addr = lut_addr_q;
    assign dac_if.dac_data = dac_data_q;
    assign dac_if.dac_send = dac_send_q;
endmodule

// File: tb/tb_nco_dac_sequencer.sv
// Bench for nco_dac_sequencer: table vectors, hand-written corner sequences
// and randomized frequency loads checked against a sample-level model.
module tb_nco_dac_sequencer;
    localparam int CH = 2, PW = 24, AW = 10, SW = 16, SI = 2015, DW = SW + 8;

    logic clk = 1'b0, rstn = 1'b0, enable = 1'b0, freq_load = 1'b0, overrun_clr = 1'b0;
    logic [1:0] freq_ch = '0;
    logic [PW-1:0] freq_in = '0;
    logic sample_tick, overrun;

    nco_dac_sequencer_if #(.LUT_ADDR_W(AW), .SAMPLE_W(SW)) bus ();

    nco_dac_sequencer #(.CHANNELS(CH), .PHASE_W(PW), .LUT_ADDR_W(AW),
                        .SAMPLE_W(SW), .SAMPLE_INTERVAL(SI)) dut (
        .clock_in(clk), .rstn(rstn), .enable(enable), .freq_load(freq_load),
        .freq_ch(freq_ch), .freq_in(freq_in), .sample_tick(sample_tick),
        .overrun(overrun), .overrun_clr(overrun_clr), .dac_if(bus));

    always #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- environment: LUT and SPI models ----------------
    logic        stub_en = 1'b1;
    logic [15:0] stub_val = 16'h1234, hash_seed = 16'h0;
    logic        force_busy = 1'b0;
    int          busy_cnt = 0;
    logic [7:0]  CMD [4] = '{8'h31, 8'h32, 8'h34, 8'h38};

    function automatic logic [15:0] lut_f(logic [AW-1:0] a);
        return stub_en ? stub_val : ((16'(a) * 16'h9E37) ^ hash_seed);
    endfunction

    function automatic logic [15:0] sx(logic [15:0] v);
`ifdef SIGNED_LUT_EN
        return v ^ 16'h8000;
`else
        return v;
`endif
    endfunction

    always @(posedge clk) bus.lut_value <= lut_f(bus.lut_addr);
    always @(posedge clk)
        if (bus.dac_send) busy_cnt <= 40;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    assign bus.dac_busy = force_busy || (busy_cnt != 0);

    // ---------------- checking ----------------
    int errors = 0, checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // reference model: timer, phases and expected words per sample period
    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;
    exp_t          expq [$];
    logic [PW-1:0] m_phase [CH], m_freq [CH];
    int            m_cnt = 0;
    bit            m_ovr = 0, m_tick, m_idle;
    longint        cyc = 0;
    longint        tick_t [$];
    logic [DW-1:0] sent [$];
    logic [AW-1:0] ch0_addrs [$];
    exp_t          e;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            m_cnt = 0; m_ovr = 0; expq.delete();
            for (int n = 0; n < CH; n++) begin m_phase[n] = '0; m_freq[n] = '0; end
        end else begin
            m_tick = enable && (m_cnt == SI - 1);
            chk("sample_tick", {63'b0, sample_tick}, {63'b0, m_tick});
            chk("overrun", {63'b0, overrun}, {63'b0, m_ovr});
            m_idle = (expq.size() == 0);
            if (m_tick) begin
                tick_t.push_back(cyc);
                if (m_idle)
                    for (int n = 0; n < CH; n++) begin
                        e.addr = m_phase[n][PW-1 -: AW];
                        e.data = {CMD[n], sx(lut_f(e.addr))};
                        expq.push_back(e);
                    end
                for (int n = 0; n < CH; n++) m_phase[n] = m_phase[n] + m_freq[n];
            end
            if (bus.dac_send) begin
                chk("send_while_busy", {63'b0, bus.dac_busy}, 64'd0);
                if (expq.size() == 0) chk("unexpected_send", 64'd1, 64'd0);
                else begin
                    e = expq.pop_front();
                    chk("dac_data", 64'(bus.dac_data), 64'(e.data));
                    chk("lut_addr", 64'(bus.lut_addr), 64'(e.addr));
                end
                sent.push_back(bus.dac_data);
                if (bus.dac_data[DW-1 -: 8] == CMD[0]) ch0_addrs.push_back(bus.lut_addr);
            end
            if (freq_load)
                for (int n = 0; n < CH; n++) if (int'(freq_ch) == n) m_freq[n] = freq_in;
            if (m_tick && !m_idle) m_ovr = 1;
            else if (overrun_clr)  m_ovr = 0;
            m_cnt = (!enable || m_tick) ? 0 : m_cnt + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(int ch, logic [PW-1:0] f);
        freq_ch = 2'(ch); freq_in = f; freq_load = 1'b1;
        cycles(1);
        freq_load = 1'b0;
    endtask

    task automatic wait_ticks(int n);
        int seen = 0, budget = n * SI + 200;
        while (seen < n && budget > 0) begin
            cycles(1);
            if (sample_tick) seen++;
            budget--;
        end
        if (seen < n) chk("tick_timeout", 64'(seen), 64'(n));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cycles(3);
        rstn = 1'b1;
    endtask

    typedef struct { logic [15:0] lut; logic [DW-1:0] e0, e1; } vec_t;
    vec_t        vecs [4];
    logic [15:0] vals [4] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h8001};
    int          s0, s1, b;

    initial begin
        for (int i = 0; i < 4; i++)
            vecs[i] = '{vals[i], {CMD[0], sx(vals[i])}, {CMD[1], sx(vals[i])}};

        // reset state
        enable = 1'b1;
        cycles(2);
        chk("rst_lut_addr", 64'(bus.lut_addr), 0);
        chk("rst_dac_data", 64'(bus.dac_data), 0);
        chk("rst_dac_send", {63'b0, bus.dac_send}, 0);
        chk("rst_tick", {63'b0, sample_tick}, 0);
        chk("rst_overrun", {63'b0, overrun}, 0);
        rstn = 1'b1;

        // table: stubbed LUT value, two words per tick
        foreach (vecs[i]) begin
            stub_val = vecs[i].lut;
            s0 = sent.size();
            wait_ticks(1);
            cycles(150);
            chk("sends_per_tick", 64'(sent.size() - s0), 2);
            if (sent.size() >= s0 + 2) begin
                chk("vec_ch0", 64'(sent[s0]), 64'(vecs[i].e0));
                chk("vec_ch1", 64'(sent[s0+1]), 64'(vecs[i].e1));
            end
        end

        // ramp: addresses step by 4, ticks exactly SI apart
        do_reset();
        load(0, 24'h010000);
        ch0_addrs.delete(); tick_t.delete();
        wait_ticks(4);
        cycles(150);
        chk("ramp_count", 64'(ch0_addrs.size()), 4);
        if (ch0_addrs.size() >= 4)
            for (int i = 0; i < 4; i++) chk("ramp_addr", 64'(ch0_addrs[i]), 64'(4 * i));
        if (tick_t.size() >= 4)
            for (int i = 0; i < 3; i++) chk("tick_spacing", 64'(tick_t[i+1] - tick_t[i]), SI);

        // wrap: half-scale step alternates 0 / 512
        do_reset();
        load(0, 24'h800000);
        ch0_addrs.delete();
        wait_ticks(4);
        cycles(150);
        chk("wrap_count", 64'(ch0_addrs.size()), 4);
        if (ch0_addrs.size() >= 4)
            for (int i = 0; i < 4; i++) chk("wrap_addr", 64'(ch0_addrs[i]), (i % 2) ? 512 : 0);

        // randomized loads (incl. ignored channels and enable gaps)
        stub_en = 1'b0;
        hash_seed = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            cycles($urandom_range(1, 1500));
            load($urandom_range(0, 3), PW'($urandom));
            if (k == 2) begin
                enable = 1'b0; cycles(300); enable = 1'b1;
            end
            wait_ticks(1);
        end
        // load landing in the tick cycle itself
        b = 3 * SI;
        cycles(1);
        while (!sample_tick && b > 0) begin cycles(1); b--; end
        freq_ch = 2'd1; freq_in = PW'($urandom); freq_load = 1'b1;
        cycles(1);
        freq_load = 1'b0;
        wait_ticks(2);
        cycles(150);
        chk("random_pending", 64'(expq.size()), 0);

        // overrun: SPI stalled across two ticks
        stub_en = 1'b1; stub_val = 16'h5A5A;
        wait_ticks(1);
        cycles(2000);
        force_busy = 1'b1;
        s0 = sent.size();
        cycles(3000);
        chk("ovr_set", {63'b0, overrun}, 1);
        chk("ovr_no_send", 64'(sent.size() - s0), 0);
        force_busy = 1'b0;
        s1 = sent.size();
        cycles(150);
        chk("ovr_frame_done", 64'(sent.size() - s1), 2);
        chk("ovr_pending", 64'(expq.size()), 0);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        chk("ovr_clr", {63'b0, overrun}, 0);

        // reset while draining
        load(0, 24'h123456);
        load(1, 24'h0F0F0F);
        wait_ticks(2);
        b = 50;
        while (!bus.dac_send && b > 0) begin cycles(1); b--; end
        cycles(3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_lut_addr", 64'(bus.lut_addr), 0);
        chk("mid_rst_dac_data", 64'(bus.dac_data), 0);
        chk("mid_rst_dac_send", {63'b0, bus.dac_send}, 0);
        chk("mid_rst_tick", {63'b0, sample_tick}, 0);
        cycles(2);
        rstn = 1'b1;
        s0 = sent.size();
        ch0_addrs.delete();
        wait_ticks(1);
        cycles(150);
        chk("post_rst_sends", 64'(sent.size() - s0), 2);
        if (ch0_addrs.size() > 0) chk("post_rst_addr", 64'(ch0_addrs[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
